// File: rtl/exec_pkg.sv
// Shared definitions for the vector execute path:
// opcodes, sequencer states and lane slicing helpers.
package exec_pkg;

  localparam logic [3:0] OP_IMM = 4'b0100;
  localparam logic [3:0] OP_SHL = 4'b0111;
  localparam logic [3:0] OP_SHR = 4'b1000;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE,
    GAP
  } seq_state_e;

  function automatic int unsigned lane_lsb(
    input int unsigned lane,
    input int unsigned n
  );
    return lane * n;
  endfunction

  function automatic int unsigned bus_width(
    input int unsigned lanes,
    input int unsigned n
  );
    return lanes * n;
  endfunction

endpackage

// File: rtl/exec_watchdog.sv
// RUN-phase watchdog: cleared on issue, counts while enabled,
// flags expiry on the TIMEOUT-th enabled cycle.
module exec_watchdog #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = en_i && (cnt_q == W'(TIMEOUT - 1));

endmodule

// File: rtl/exec_sequencer.sv
// Vector execute sequencer: issues one instruction to the lanes,
// waits for completion or watchdog abort, hands result to writeback.
module exec_sequencer
  import exec_pkg::*;
#(
  parameter int N            = 32,
  parameter int WIDTH_VECTOR = 24,
  parameter int WIDTH_OPCODE = 4,
  parameter int TIMEOUT      = 64,
  parameter int CNT_W        = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH_VECTOR-1:0]   in_mask,
  input  logic [WIDTH_OPCODE-1:0]   in_opcode,
  input  logic [WIDTH_VECTOR*N-1:0] in_dataA,
  input  logic [WIDTH_VECTOR*N-1:0] in_dataB,
  input  logic [WIDTH_VECTOR-1:0]   in_imm,
  output logic [WIDTH_VECTOR-1:0]   exe_enable,
  output logic [WIDTH_OPCODE-1:0]   exe_opcode,
  output logic [WIDTH_VECTOR*N-1:0] exe_dataA,
  output logic [WIDTH_VECTOR*N-1:0] exe_dataB,
  output logic [WIDTH_VECTOR-1:0]   exe_imm,
  input  logic                      exe_valid,
  input  logic                      exe_zero,
  input  logic [WIDTH_VECTOR*N-1:0] exe_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH_VECTOR*N-1:0] out_data,
  output logic                      out_zero,
  output logic                      out_err,
  output logic [CNT_W-1:0]          retired
);

  localparam int DW = WIDTH_VECTOR * N;

  seq_state_e state_q, state_d;

  logic [WIDTH_VECTOR-1:0] mask_q, mask_d;
  logic [WIDTH_OPCODE-1:0] opc_q, opc_d;
  logic [DW-1:0]           a_q, a_d;
  logic [DW-1:0]           b_q, b_d;
  logic [WIDTH_VECTOR-1:0] imm_q, imm_d;
  logic [DW-1:0]           res_q, res_d;
  logic                    zero_q, zero_d;
  logic                    err_q, err_d;
  logic [CNT_W-1:0]        ret_q, ret_d;

  logic issue;
  logic wd_expire;

  assign issue = (state_q == IDLE) && in_valid && (in_mask != '0);

  exec_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wd (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (issue),
    .en_i     (state_q == RUN),
    .expire_o (wd_expire)
  );

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    opc_d   = opc_q;
    a_d     = a_q;
    b_d     = b_q;
    imm_d   = imm_q;
    res_d   = res_q;
    zero_d  = zero_q;
    err_d   = err_q;
    ret_d   = ret_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          mask_d = in_mask;
          opc_d  = in_opcode;
          a_d    = in_dataA;
          b_d    = in_dataB;
          imm_d  = in_imm;
          if (in_mask != '0) begin
            state_d = RUN;
          end else begin
            // no lane enabled: complete without touching execute
            res_d   = '0;
            zero_d  = 1'b1;
            err_d   = 1'b0;
            state_d = DONE;
          end
        end
      end
      RUN: begin
        if (exe_valid) begin
          res_d   = exe_data;
          zero_d  = exe_zero;
          err_d   = 1'b0;
          state_d = DONE;
        end else if (wd_expire) begin
          res_d   = '0;
          zero_d  = 1'b0;
          err_d   = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          ret_d   = ret_q + CNT_W'(1);
          state_d = GAP;
        end
      end
      GAP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mask_q  <= '0;
      opc_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      imm_q   <= '0;
      res_q   <= '0;
      zero_q  <= 1'b0;
      err_q   <= 1'b0;
      ret_q   <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      opc_q   <= opc_d;
      a_q     <= a_d;
      b_q     <= b_d;
      imm_q   <= imm_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
      err_q   <= err_d;
      ret_q   <= ret_d;
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign exe_enable = (state_q == RUN) ? mask_q : '0;
  assign exe_opcode = opc_q;
  assign exe_dataA  = a_q;
  assign exe_dataB  = b_q;
  assign exe_imm    = imm_q;
  assign out_valid  = (state_q == DONE);
  assign out_data   = res_q;
  assign out_zero   = zero_q;
  assign out_err    = err_q;
  assign retired    = ret_q;

endmodule

// File: tb/tb_exec_sequencer.sv
// Directed bench for exec_sequencer with a small stub execute unit.
module tb_exec_sequencer;

  localparam int N  = 32;
  localparam int WV = 24;
  localparam int WO = 4;
  localparam int TO = 8;
  localparam int CW = 4;
  localparam int DW = WV * N;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [WV-1:0] in_mask;
  logic [WO-1:0] in_opcode;
  logic [DW-1:0] in_dataA;
  logic [DW-1:0] in_dataB;
  logic [WV-1:0] in_imm;
  logic [WV-1:0] exe_enable;
  logic [WO-1:0] exe_opcode;
  logic [DW-1:0] exe_dataA;
  logic [DW-1:0] exe_dataB;
  logic [WV-1:0] exe_imm;
  logic          exe_valid;
  logic          exe_zero;
  logic [DW-1:0] exe_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_zero;
  logic          out_err;
  logic [CW-1:0] retired;

  // stub execute: echo mode answers in the first RUN cycle with ~A
  logic          echo;
  logic          exe_valid_r;
  logic          exe_zero_r;
  logic [DW-1:0] exe_data_r;

  assign exe_valid = echo ? (exe_enable != '0) : exe_valid_r;
  assign exe_data  = echo ? ~exe_dataA : exe_data_r;
  assign exe_zero  = exe_zero_r;

  int errors = 0;
  int checks = 0;
  int exp_ret = 0;

  always #5 clk = ~clk;

  exec_sequencer #(
    .N(N), .WIDTH_VECTOR(WV), .WIDTH_OPCODE(WO),
    .TIMEOUT(TO), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_mask(in_mask), .in_opcode(in_opcode),
    .in_dataA(in_dataA), .in_dataB(in_dataB), .in_imm(in_imm),
    .exe_enable(exe_enable), .exe_opcode(exe_opcode),
    .exe_dataA(exe_dataA), .exe_dataB(exe_dataB), .exe_imm(exe_imm),
    .exe_valid(exe_valid), .exe_zero(exe_zero), .exe_data(exe_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_zero(out_zero), .out_err(out_err),
    .retired(retired)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] fill(input logic [N-1:0] v);
    logic [DW-1:0] r;
    for (int i = 0; i < WV; i++) r[i*N +: N] = v;
    return r;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      errors++;
      $display("FAIL reset_hs: got %b want 10", {in_ready, out_valid});
    end
    checks++;
    if (exe_enable !== '0 || retired !== '0) begin
      errors++;
      $display("FAIL reset_out: en=%h ret=%0d want 0", exe_enable, retired);
    end
    in_valid  = 1'b1;
    in_mask   = 24'h00F0F0;
    in_opcode = 4'b0111;
    in_dataA  = fill(32'h1234);
    tick();
    in_valid = 1'b0;
    checks++;
    if (exe_enable !== 24'h00F0F0) begin
      errors++;
      $display("FAIL reset_run: en=%h want 00f0f0", exe_enable);
    end
    tick();
    rst = 1'b1;
    tick();
    checks++;
    if (exe_enable !== '0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: en=%h ov=%b want 0", exe_enable, out_valid);
    end
    tick();
    tick();
    rst = 1'b0;
    checks++;
    if ({in_ready, out_valid, exe_enable} !== {2'b10, 24'h0} || retired !== '0) begin
      errors++;
      $display("FAIL reset_rel: rdy=%b ov=%b en=%h ret=%0d want 1 0 0 0",
               in_ready, out_valid, exe_enable, retired);
    end
    exp_ret = 0;
  endtask

  task automatic test_normal();
    logic [DW-1:0] a, b, r;
    a = fill(32'hA5A50000);
    b = fill(32'h00005A5A);
    r = fill(32'h00010000);
    in_valid  = 1'b1;
    in_mask   = 24'hFFFFFF;
    in_opcode = 4'b0001;
    in_dataA  = a;
    in_dataB  = b;
    in_imm    = 24'hFFFFF0;
    tick();
    in_valid = 1'b0;
    checks++;
    if ({exe_enable, exe_opcode, exe_imm} !== {24'hFFFFFF, 4'b0001, 24'hFFFFF0}) begin
      errors++;
      $display("FAIL norm_issue: en=%h op=%h imm=%h", exe_enable, exe_opcode, exe_imm);
    end
    checks++;
    if (exe_dataA !== a || exe_dataB !== b) begin
      errors++;
      $display("FAIL norm_ops: a=%h b=%h", exe_dataA[31:0], exe_dataB[31:0]);
    end
    tick();
    checks++;
    if (exe_enable !== 24'hFFFFFF || in_ready !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL norm_run2: en=%h rdy=%b ov=%b", exe_enable, in_ready, out_valid);
    end
    tick();
    exe_valid_r = 1'b1;
    exe_data_r  = r;
    exe_zero_r  = 1'b0;
    tick();
    exe_valid_r = 1'b0;
    exe_data_r  = '0;
    checks++;
    if ({out_valid, out_err, out_zero, in_ready} !== 4'b1000 || exe_enable !== '0) begin
      errors++;
      $display("FAIL norm_done: v/e/z/r=%b en=%h want 1000 0",
               {out_valid, out_err, out_zero, in_ready}, exe_enable);
    end
    checks++;
    if (out_data !== r) begin
      errors++;
      $display("FAIL norm_data: got %h want %h", out_data, r);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    exp_ret++;
    checks++;
    if ({out_valid, in_ready} !== 2'b00 || retired !== CW'(exp_ret)) begin
      errors++;
      $display("FAIL norm_gap: ov=%b rdy=%b ret=%0d want 0 0 %0d",
               out_valid, in_ready, retired, exp_ret);
    end
    tick();
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL norm_idle: rdy=%b want 1", in_ready);
    end
  endtask

  task automatic test_back_to_back();
    int acc_cyc[4];
    int k, nout;
    logic acc, hs;
    echo      = 1'b1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_mask   = 24'h0F0F0F;
    in_opcode = 4'd0;
    in_dataA  = fill(32'h100);
    k    = 0;
    nout = 0;
    for (int cyc = 0; cyc < 40 && nout < 4; cyc++) begin
      acc = in_ready && in_valid;
      hs  = out_valid && out_ready;
      if (hs) begin
        checks++;
        if (out_data !== ~fill(32'h100 + nout) || out_err !== 1'b0) begin
          errors++;
          $display("FAIL b2b_data%0d: got %h err=%b want %h", nout,
                   out_data[31:0], out_err, ~(32'h100 + nout));
        end
        nout++;
        exp_ret++;
      end
      tick();
      if (acc) begin
        acc_cyc[k] = cyc;
        k++;
        if (k < 4) begin
          in_dataA  = fill(32'h100 + k);
          in_opcode = WO'(k);
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    checks++;
    if (nout != 4 || k != 4) begin
      errors++;
      $display("FAIL b2b_count: accepts=%0d results=%0d want 4 4", k, nout);
    end else begin
      for (int i = 1; i < 4; i++) begin
        checks++;
        if (acc_cyc[i] - acc_cyc[i-1] != 4) begin
          errors++;
          $display("FAIL b2b_gap%0d: got %0d want 4", i, acc_cyc[i] - acc_cyc[i-1]);
        end
      end
    end
    checks++;
    if (retired !== CW'(exp_ret)) begin
      errors++;
      $display("FAIL b2b_ret: got %0d want %0d", retired, exp_ret % 16);
    end
    out_ready = 1'b0;
    echo      = 1'b0;
    in_valid  = 1'b0;
    tick();
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] exp;
    int n;
    exp        = ~fill(32'hDEAD0000);
    echo       = 1'b1;
    exe_zero_r = 1'b1;
    out_ready  = 1'b0;
    in_valid   = 1'b1;
    in_mask    = 24'h0000FF;
    in_dataA   = fill(32'hDEAD0000);
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 10) begin
      tick();
      n++;
    end
    echo       = 1'b0;
    exe_data_r = '0;
    exe_zero_r = 1'b0;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if ({out_valid, out_zero, out_err, in_ready} !== 4'b1100 || exe_enable !== '0) begin
        errors++;
        $display("FAIL bp_ctl%0d: v/z/e/r=%b en=%h want 1100 0", i,
                 {out_valid, out_zero, out_err, in_ready}, exe_enable);
      end
      checks++;
      if (out_data !== exp) begin
        errors++;
        $display("FAIL bp_data%0d: got %h want %h", i, out_data[31:0], exp[31:0]);
      end
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    exp_ret++;
    checks++;
    if (out_valid !== 1'b0 || retired !== CW'(exp_ret)) begin
      errors++;
      $display("FAIL bp_release: ov=%b ret=%0d want 0 %0d", out_valid, retired, exp_ret % 16);
    end
    tick();
  endtask

  task automatic test_timeout();
    int runs, n;
    echo        = 1'b0;
    exe_valid_r = 1'b0;
    exe_data_r  = fill(32'hFFFF);
    exe_zero_r  = 1'b1;
    in_valid    = 1'b1;
    in_mask     = 24'h000001;
    in_dataA    = fill(32'h7);
    tick();
    in_valid = 1'b0;
    runs = 0;
    n    = 0;
    while (!out_valid && n < 20) begin
      if (exe_enable != '0) runs++;
      tick();
      n++;
    end
    checks++;
    if (runs != TO || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL to_len: run cycles=%0d ov=%b want %0d 1", runs, out_valid, TO);
    end
    checks++;
    if ({out_err, out_zero} !== 2'b10 || out_data !== '0) begin
      errors++;
      $display("FAIL to_res: err=%b zero=%b data=%h want 1 0 0",
               out_err, out_zero, out_data[31:0]);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    exp_ret++;
    tick();
    echo     = 1'b1;
    in_valid = 1'b1;
    in_dataA = fill(32'h77);
    tick();
    in_valid = 1'b0;
    tick();
    checks++;
    if ({out_valid, out_err} !== 2'b10 || out_data !== ~fill(32'h77)) begin
      errors++;
      $display("FAIL to_next: ov=%b err=%b data=%h", out_valid, out_err, out_data[31:0]);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    exp_ret++;
    echo = 1'b0;
    tick();
    checks++;
    if (retired !== CW'(exp_ret)) begin
      errors++;
      $display("FAIL to_ret: got %0d want %0d", retired, exp_ret % 16);
    end
  endtask

  task automatic test_empty();
    echo        = 1'b0;
    exe_valid_r = 1'b1;
    exe_data_r  = fill(32'h1111);
    exe_zero_r  = 1'b0;
    in_valid    = 1'b1;
    in_mask     = '0;
    tick();
    in_valid = 1'b0;
    checks++;
    if ({out_valid, out_zero, out_err} !== 3'b110 || exe_enable !== '0) begin
      errors++;
      $display("FAIL empty_ctl: v/z/e=%b en=%h want 110 0",
               {out_valid, out_zero, out_err}, exe_enable);
    end
    checks++;
    if (out_data !== '0) begin
      errors++;
      $display("FAIL empty_data: got %h want 0", out_data[31:0]);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    exp_ret++;
    checks++;
    if (exe_enable !== '0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL empty_gap: en=%h ov=%b want 0", exe_enable, out_valid);
    end
    exe_valid_r = 1'b0;
    tick();
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 12; i++) begin
      in_valid = 1'b1;
      in_mask  = '0;
      tick();
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      exp_ret++;
      tick();
      checks++;
      if (retired !== CW'(exp_ret)) begin
        errors++;
        $display("FAIL wrap%0d: got %0d want %0d", i, retired, exp_ret % 16);
      end
    end
  endtask

  initial begin
    rst         = 1'b1;
    in_valid    = 1'b0;
    in_mask     = '0;
    in_opcode   = '0;
    in_dataA    = '0;
    in_dataB    = '0;
    in_imm      = '0;
    out_ready   = 1'b0;
    echo        = 1'b0;
    exe_valid_r = 1'b0;
    exe_zero_r  = 1'b0;
    exe_data_r  = '0;
    test_reset();
    test_normal();
    test_back_to_back();
    test_backpressure();
    test_timeout();
    test_empty();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end

endmodule
